// File: rtl/motor3_pkg.sv
// Shared definitions for the motor3 gate-command monitor: phase-state encoding,
// the 6-step commutation table and step arithmetic helpers.
package motor3_pkg;

  typedef enum logic [1:0] {
    PH_OFF   = 2'b00,
    PH_LOW   = 2'b01,
    PH_HIGH  = 2'b10,
    PH_SHOOT = 2'b11
  } phase_t;

  localparam int         PHASES       = 3;
  localparam logic [2:0] STEP_INVALID = 3'd7;
  localparam logic [2:0] STEP_LAST    = 3'd5;

  // {A,B,C} phase states that identify each commutation step
  localparam logic [5:0] STEP_PAT_0 = 6'b10_01_00;
  localparam logic [5:0] STEP_PAT_1 = 6'b10_00_01;
  localparam logic [5:0] STEP_PAT_2 = 6'b00_10_01;
  localparam logic [5:0] STEP_PAT_3 = 6'b01_10_00;
  localparam logic [5:0] STEP_PAT_4 = 6'b01_00_10;
  localparam logic [5:0] STEP_PAT_5 = 6'b00_01_10;

  function automatic logic [2:0] step_decode(input phase_t a, input phase_t b, input phase_t c);
    logic [5:0] pat;
    logic [2:0] step;
    pat = {a, b, c};
    case (pat)
      STEP_PAT_0: step = 3'd0;
      STEP_PAT_1: step = 3'd1;
      STEP_PAT_2: step = 3'd2;
      STEP_PAT_3: step = 3'd3;
      STEP_PAT_4: step = 3'd4;
      STEP_PAT_5: step = 3'd5;
      default:    step = STEP_INVALID;
    endcase
    return step;
  endfunction

  function automatic logic [2:0] step_next(input logic [2:0] s);
    logic [2:0] n;
    if (s >= STEP_LAST) begin
      n = 3'd0;
    end else begin
      n = s + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [2:0] step_prev(input logic [2:0] s);
    logic [2:0] n;
    if (s == 3'd0) begin
      n = STEP_LAST;
    end else begin
      n = s - 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/motor3_phase_check.sv
// One gate-command pair: input register, phase-state decode, dead-time counter
// and single-cycle shoot-through / dead-time violation indications.
module motor3_phase_check
  import motor3_pkg::*;
#(
  parameter int DEADTIME_MIN = 2
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   hp,
  input  logic   lp_n,
  output phase_t state,
  output logic   shoot,
  output logic   dt_viol
);

  localparam int CNT_W = (DEADTIME_MIN < 1) ? 1 : $clog2(DEADTIME_MIN + 1);
  localparam logic [CNT_W-1:0] DT_SAT = CNT_W'(DEADTIME_MIN);

  logic             hp_r;
  logic             lp_n_r;
  phase_t           prev_r;
  logic [CNT_W-1:0] dt_cnt_r;
  logic [CNT_W-1:0] dt_cnt_nxt;
  phase_t           state_s;

  // Pin sampling, previous-state history and dead-time counter
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hp_r     <= 1'b0;
      lp_n_r   <= 1'b1;
      prev_r   <= PH_OFF;
      dt_cnt_r <= DT_SAT;
    end else begin
      hp_r     <= hp;
      lp_n_r   <= lp_n;
      prev_r   <= state_s;
      dt_cnt_r <= dt_cnt_nxt;
    end
  end

  // The counter holds the number of OFF cycles seen before the current one
  always_comb begin
    state_s    = phase_t'({hp_r, ~lp_n_r});
    dt_cnt_nxt = {CNT_W{1'b0}};
    if (state_s == PH_OFF) begin
      if (dt_cnt_r >= DT_SAT) begin
        dt_cnt_nxt = DT_SAT;
      end else begin
        dt_cnt_nxt = dt_cnt_r + CNT_W'(1);
      end
    end else begin
      dt_cnt_nxt = {CNT_W{1'b0}};
    end
  end

  // Violation classification; SHOOT entry and exit are left to the shoot flag
  always_comb begin
    shoot   = (state_s == PH_SHOOT);
    dt_viol = 1'b0;
    case (prev_r)
      PH_OFF:  dt_viol = ((state_s == PH_HIGH) || (state_s == PH_LOW)) && (dt_cnt_r < DT_SAT);
      PH_HIGH: dt_viol = (state_s == PH_LOW);
      PH_LOW:  dt_viol = (state_s == PH_HIGH);
      default: dt_viol = 1'b0;
    endcase
  end

  assign state = state_s;

endmodule

// File: rtl/motor3_gate_monitor.sv
// Receive-side checker for three IRS2007S gate pairs: sticky fault masks,
// 6-step commutation decode, direction/skip tracking and step-period measurement.
module motor3_gate_monitor
  import motor3_pkg::*;
#(
  parameter int DEADTIME_MIN = 2,
  parameter int PERIOD_W     = 16
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                aHpI,
  input  logic                aLpI,
  input  logic                bHpI,
  input  logic                bLpI,
  input  logic                cHpI,
  input  logic                cLpI,
  input  logic                faultClrI,
  output logic [2:0]          shootO,
  output logic [2:0]          dtViolO,
  output logic                faultO,
  output logic [2:0]          stepO,
  output logic                stepSkipO,
  output logic                dirO,
  output logic [PERIOD_W-1:0] stepPeriodO,
  output logic                periodValidO,
  output logic                stallO
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  logic [PHASES-1:0] hp_s;
  logic [PHASES-1:0] lp_n_s;
  phase_t            phase_s [PHASES];
  logic [PHASES-1:0] shoot_evt_s;
  logic [PHASES-1:0] dt_evt_s;

  assign hp_s   = {cHpI, bHpI, aHpI};
  assign lp_n_s = {cLpI, bLpI, aLpI};

  for (genvar p = 0; p < PHASES; p++) begin : g_phase
    motor3_phase_check #(
      .DEADTIME_MIN(DEADTIME_MIN)
    ) u_check (
      .clk    (clkI),
      .n_rst  (nRstI),
      .hp     (hp_s[p]),
      .lp_n   (lp_n_s[p]),
      .state  (phase_s[p]),
      .shoot  (shoot_evt_s[p]),
      .dt_viol(dt_evt_s[p])
    );
  end

  logic [2:0]          shoot_r;
  logic [2:0]          dt_viol_r;
  logic                fault_r;
  logic [2:0]          step_r;
  logic [2:0]          last_step_r;
  logic                skip_r;
  logic                dir_r;
  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] period_r;
  logic                seen_chg_r;
  logic                period_valid_r;
  logic                stall_r;

  logic [2:0]          step_s;
  logic                step_chg_s;
  logic                fwd_s;
  logic                rev_s;
  logic                skip_evt_s;
  logic [2:0]          shoot_nxt;
  logic [2:0]          dt_viol_nxt;
  logic                skip_nxt;
  logic                dir_nxt;
  logic [2:0]          last_step_nxt;
  logic [PERIOD_W-1:0] cnt_inc_s;
  logic [PERIOD_W-1:0] cnt_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic                period_valid_nxt;

  // Step decode and classification of valid-to-valid step changes
  always_comb begin
    step_s     = step_decode(phase_s[0], phase_s[1], phase_s[2]);
    step_chg_s = 1'b0;
    fwd_s      = 1'b0;
    rev_s      = 1'b0;
    skip_evt_s = 1'b0;
    if ((step_s != STEP_INVALID) && (last_step_r != STEP_INVALID) && (step_s != last_step_r)) begin
      step_chg_s = 1'b1;
      if (step_s == step_next(last_step_r)) begin
        fwd_s = 1'b1;
      end else if (step_s == step_prev(last_step_r)) begin
        rev_s = 1'b1;
      end else begin
        skip_evt_s = 1'b1;
      end
    end else begin
      step_chg_s = 1'b0;
    end
  end

  // Next values for masks, direction and period measurement
  always_comb begin
    shoot_nxt        = (faultClrI ? 3'b000 : shoot_r) | shoot_evt_s;
    dt_viol_nxt      = (faultClrI ? 3'b000 : dt_viol_r) | dt_evt_s;
    skip_nxt         = (faultClrI ? 1'b0 : skip_r) | skip_evt_s;
    dir_nxt          = dir_r;
    last_step_nxt    = last_step_r;
    cnt_inc_s        = cnt_r;
    cnt_nxt          = cnt_r;
    period_nxt       = period_r;
    period_valid_nxt = period_valid_r;

    if (fwd_s) begin
      dir_nxt = 1'b1;
    end else if (rev_s) begin
      dir_nxt = 1'b0;
    end else begin
      dir_nxt = dir_r;
    end

    if (step_s != STEP_INVALID) begin
      last_step_nxt = step_s;
    end else begin
      last_step_nxt = last_step_r;
    end

    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = cnt_r + PERIOD_W'(1);
    end

    // The first change only closes the interval that began at reset
    if (step_chg_s) begin
      cnt_nxt          = {PERIOD_W{1'b0}};
      period_nxt       = cnt_inc_s;
      period_valid_nxt = period_valid_r | seen_chg_r;
    end else begin
      cnt_nxt          = cnt_inc_s;
      period_nxt       = period_r;
      period_valid_nxt = period_valid_r;
    end
  end

  // Registered outputs and step history
  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      shoot_r        <= 3'b000;
      dt_viol_r      <= 3'b000;
      fault_r        <= 1'b0;
      step_r         <= STEP_INVALID;
      last_step_r    <= STEP_INVALID;
      skip_r         <= 1'b0;
      dir_r          <= 1'b0;
      cnt_r          <= {PERIOD_W{1'b0}};
      period_r       <= {PERIOD_W{1'b0}};
      seen_chg_r     <= 1'b0;
      period_valid_r <= 1'b0;
      stall_r        <= 1'b0;
    end else begin
      shoot_r        <= shoot_nxt;
      dt_viol_r      <= dt_viol_nxt;
      fault_r        <= (|shoot_nxt) | (|dt_viol_nxt);
      step_r         <= step_s;
      last_step_r    <= last_step_nxt;
      skip_r         <= skip_nxt;
      dir_r          <= dir_nxt;
      cnt_r          <= cnt_nxt;
      period_r       <= period_nxt;
      seen_chg_r     <= seen_chg_r | step_chg_s;
      period_valid_r <= period_valid_nxt;
      stall_r        <= (cnt_nxt == CNT_MAX);
    end
  end

  assign shootO       = shoot_r;
  assign dtViolO      = dt_viol_r;
  assign faultO       = fault_r;
  assign stepO        = step_r;
  assign stepSkipO    = skip_r;
  assign dirO         = dir_r;
  assign stepPeriodO  = period_r;
  assign periodValidO = period_valid_r;
  assign stallO       = stall_r;

endmodule
